// File: rtl/fp_addsub_result_fifo.sv
// Result FIFO for the single-precision add/sub datapath: buffers {result, flags}.
// Optional sticky-flag accumulation is enabled by defining FPADDSUB_STICKY_FLAGS_EN.
module fp_addsub_result_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [31:0]   in_result,
    input  logic [4:0]    in_flags,
    output logic          in_ready,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_result,
    output logic [4:0]    out_flags,
    output logic [AW:0]   count,
    input  logic          clr_sticky,
    output logic [4:0]    flags_sticky,
    output logic          overflow_err
);

    localparam logic [AW:0] LP_FULL = DEPTH[AW:0];

    logic [36:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [AW:0]   r_count;
    logic          r_ovf;
    logic          w_push;
    logic          w_pop;
    logic          w_in_ready;
    logic          w_out_valid;
    logic [36:0]   w_head;

    // Readiness comes only from registered occupancy, so a full FIFO never
    // accepts a push even when the consumer pops in the same cycle.
    assign w_in_ready  = (r_count != LP_FULL);
    assign w_out_valid = (r_count != '0);
    assign w_push      = in_valid & w_in_ready;
    assign w_pop       = w_out_valid & out_ready;
    assign w_head      = r_mem[r_rp];

    assign in_ready     = w_in_ready;
    assign out_valid    = w_out_valid;
    assign out_result   = w_head[36:5];
    assign out_flags    = w_head[4:0];
    assign count        = r_count;
    assign overflow_err = r_ovf;

    // Storage array: written at the tail on push, cleared on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wp] <= {in_result, in_flags};
        end
    end

    // Pointers wrap naturally modulo DEPTH; occupancy tracks push/pop balance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wp <= r_wp + AW'(1);
            end
            if (w_pop) begin
                r_rp <= r_rp + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + (AW+1)'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - (AW+1)'(1);
            end
        end
    end

    // Overflow is sticky until reset: any valid input seen while full.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ovf <= 1'b0;
        end else if (in_valid && !w_in_ready) begin
            r_ovf <= 1'b1;
        end
    end

`ifdef FPADDSUB_STICKY_FLAGS_EN
    logic [4:0] r_sticky;

    // Clear takes priority, then the same-cycle push accumulates on top.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sticky <= '0;
        end else if (clr_sticky) begin
            r_sticky <= w_push ? in_flags : 5'b0;
        end else if (w_push) begin
            r_sticky <= r_sticky | in_flags;
        end
    end

    assign flags_sticky = r_sticky;
`else
    // Feature disabled: constant zero; clr_sticky has no effect.
    assign flags_sticky = 5'b0 & {5{clr_sticky}};
`endif

endmodule

// File: tb/tb_fp_addsub_result_fifo.sv
// Directed self-checking bench for fp_addsub_result_fifo (DEPTH=4).
// Sticky-flag expectations follow FPADDSUB_STICKY_FLAGS_EN.
module tb_fp_addsub_result_fifo;

`ifdef FPADDSUB_STICKY_FLAGS_EN
    localparam bit STK = 1'b1;
`else
    localparam bit STK = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_result;
    logic [4:0]  in_flags;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_flags;
    logic [2:0]  count;
    logic        clr_sticky;
    logic [4:0]  flags_sticky;
    logic        overflow_err;

    int checks;
    int failures;

    fp_addsub_result_fifo #(.DEPTH(4), .AW(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_result    (in_result),
        .in_flags     (in_flags),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_flags    (out_flags),
        .count        (count),
        .clr_sticky   (clr_sticky),
        .flags_sticky (flags_sticky),
        .overflow_err (overflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (time %0t, required < 200000)", $time);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid   = 1'b0;
        in_result  = '0;
        in_flags   = '0;
        out_ready  = 1'b0;
        clr_sticky = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        tick();
        checks++;
        if (in_ready !== 1'b1) begin
            failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid);
        end
        checks++;
        if (count !== 3'd0) begin
            failures++; $display("FAIL reset_count got=%0d exp=0", count);
        end
        checks++;
        if (out_result !== 32'h0 || out_flags !== 5'h0) begin
            failures++; $display("FAIL reset_head got=%h/%b exp=0/0", out_result, out_flags);
        end
        checks++;
        if (flags_sticky !== 5'b0 || overflow_err !== 1'b0) begin
            failures++; $display("FAIL reset_sticky got=%b/%b exp=0/0", flags_sticky, overflow_err);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_single();
        do_reset();
        in_valid  = 1'b1;
        in_result = 32'h3F800000;
        in_flags  = 5'b00001;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++; $display("FAIL single_no_bypass got=%b exp=0", out_valid);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || count !== 3'd1) begin
            failures++; $display("FAIL single_valid got=%b/%0d exp=1/1", out_valid, count);
        end
        checks++;
        if (out_result !== 32'h3F800000 || out_flags !== 5'b00001) begin
            failures++; $display("FAIL single_data got=%h/%b exp=3f800000/00001", out_result, out_flags);
        end
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_result !== 32'h3F800000 || count !== 3'd1) begin
            failures++; $display("FAIL single_hold got=%b/%h/%0d exp=1/3f800000/1", out_valid, out_result, count);
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0 || count !== 3'd0) begin
            failures++; $display("FAIL single_pop got=%b/%0d exp=0/0", out_valid, count);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || count !== 3'd0) begin
            failures++; $display("FAIL empty_ready_noop got=%b/%0d exp=0/0", out_valid, count);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_fill_overflow();
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            in_valid  = 1'b1;
            in_result = 32'(i);
            in_flags  = 5'(i);
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0 || count !== 3'd4 || overflow_err !== 1'b0) begin
            failures++; $display("FAIL full_state got=%b/%0d/%b exp=0/4/0", in_ready, count, overflow_err);
        end
        in_valid  = 1'b1;
        in_result = 32'h5;
        tick();
        in_valid = 1'b0;
        checks++;
        if (overflow_err !== 1'b1 || count !== 3'd4) begin
            failures++; $display("FAIL overflow got=%b/%0d exp=1/4", overflow_err, count);
        end
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_result !== 32'(i) || out_flags !== 5'(i)) begin
                failures++; $display("FAIL drain_order got=%b/%h/%b exp=1/%h/%b", out_valid, out_result, out_flags, 32'(i), 5'(i));
            end
            tick();
        end
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || count !== 3'd0 || overflow_err !== 1'b1) begin
            failures++; $display("FAIL drain_end got=%b/%0d/%b exp=0/0/1", out_valid, count, overflow_err);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) begin
            in_valid  = 1'b1;
            in_result = 32'hA0 + 32'(i);
            tick();
        end
        in_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || count !== 3'd0 || in_ready !== 1'b1 || overflow_err !== 1'b0) begin
            failures++; $display("FAIL async_reset got=%b/%0d/%b/%b exp=0/0/1/0", out_valid, count, in_ready, overflow_err);
        end
        #1;
        rst = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0 || count !== 3'd0) begin
            failures++; $display("FAIL async_reset_after got=%b/%0d exp=0/0", out_valid, count);
        end
    endtask

    task automatic test_full_pop();
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            in_valid  = 1'b1;
            in_result = 32'(i);
            in_flags  = 5'b0;
            tick();
        end
        in_result = 32'h9;
        out_ready = 1'b1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++; $display("FAIL fullpop_ready_before got=%b exp=0", in_ready);
        end
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (count !== 3'd3 || in_ready !== 1'b1 || overflow_err !== 1'b1) begin
            failures++; $display("FAIL fullpop_state got=%0d/%b/%b exp=3/1/1", count, in_ready, overflow_err);
        end
        out_ready = 1'b1;
        for (int i = 2; i <= 4; i++) begin
            checks++;
            if (out_result !== 32'(i)) begin
                failures++; $display("FAIL fullpop_drain got=%h exp=%h", out_result, 32'(i));
            end
            tick();
        end
        out_ready = 1'b0;
        checks++;
        if (count !== 3'd0 || out_valid !== 1'b0) begin
            failures++; $display("FAIL fullpop_dropped got=%0d/%b exp=0/0", count, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] q[$];
        do_reset();
        in_valid  = 1'b1;
        in_result = 32'd100;
        out_ready = 1'b1;
        tick();
        q.push_back(32'd100);
        checks++;
        if (count !== 3'd1) begin
            failures++; $display("FAIL empty_push_pop got=%0d exp=1", count);
        end
        in_result = 32'd101;
        out_ready = 1'b0;
        tick();
        q.push_back(32'd101);
        for (int i = 0; i < 20; i++) begin
            in_valid  = 1'b1;
            in_result = 32'd102 + 32'(i);
            out_ready = 1'b1;
            checks++;
            if (out_result !== q[0]) begin
                failures++; $display("FAIL stream_head got=%0d exp=%0d", out_result, q[0]);
            end
            tick();
            void'(q.pop_front());
            q.push_back(32'd102 + 32'(i));
            checks++;
            if (count !== 3'd2) begin
                failures++; $display("FAIL stream_count got=%0d exp=2", count);
            end
        end
        in_valid = 1'b0;
        while (q.size() > 0) begin
            checks++;
            if (out_valid !== 1'b1 || out_result !== q[0]) begin
                failures++; $display("FAIL stream_drain got=%b/%0d exp=1/%0d", out_valid, out_result, q[0]);
            end
            tick();
            void'(q.pop_front());
        end
        out_ready = 1'b0;
        checks++;
        if (count !== 3'd0) begin
            failures++; $display("FAIL stream_end got=%0d exp=0", count);
        end
    endtask

    task automatic test_sticky();
        logic [4:0] exp;
        do_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_flags  = 5'b00100;
        tick();
        in_flags = 5'b10000;
        tick();
        in_valid = 1'b0;
        exp = STK ? 5'b10100 : 5'b00000;
        checks++;
        if (flags_sticky !== exp) begin
            failures++; $display("FAIL sticky_accum got=%b exp=%b", flags_sticky, exp);
        end
        in_valid   = 1'b1;
        in_flags   = 5'b00001;
        clr_sticky = 1'b1;
        tick();
        in_valid = 1'b0;
        exp = STK ? 5'b00001 : 5'b00000;
        checks++;
        if (flags_sticky !== exp) begin
            failures++; $display("FAIL sticky_clr_push got=%b exp=%b", flags_sticky, exp);
        end
        tick();
        clr_sticky = 1'b0;
        checks++;
        if (flags_sticky !== 5'b0) begin
            failures++; $display("FAIL sticky_clr got=%b exp=00000", flags_sticky);
        end
        out_ready = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        idle_inputs();
        rst = 1'b1;
        #2;
        test_reset();
        test_single();
        test_fill_overflow();
        test_async_reset();
        test_full_pop();
        test_back_to_back();
        test_sticky();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fp_addsub_result_fifo.md
# fp_addsub_result_fifo

Downstream result stage for the single-precision add/sub datapath: captures each 32-bit result and 5-bit IEEE754 exception flag vector produced by the adder, buffers them in a small FIFO, and presents them to the consumer over a valid/ready handshake. It also keeps a sticky OR of all accepted exception flags and a sticky overflow error for pushes dropped while full. It sits between the adder output (result, flags, plus an upstream-generated valid) and the writeback/accumulator logic.

## Interface
- DEPTH, 4, number of FIFO entries; power of two, ≥ 2
- AW, 2, pointer width = log2(DEPTH); must match DEPTH
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset
- in_valid  input  1  adder output valid this cycle
- in_result  input  32  adder result
- in_flags  input  5  adder exception flags
- in_ready  output  1  FIFO not full
- out_valid  output  1  head entry available
- out_ready  input  1  consumer accepts head
- out_result  output  32  head result
- out_flags  output  5  head flags
- count  output  AW+1  current occupancy, 0..DEPTH
- clr_sticky  input  1  clear sticky flags
- flags_sticky  output  5  OR of flags of all accepted entries since last clear
- overflow_err  output  1  sticky: a push arrived while full; cleared only by reset

## Operation
- Storage: DEPTH × 37-bit array {result, flags}; write pointer wp, read pointer rp, both AW bits, wrap modulo DEPTH; count AW+1 bits.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = (count != DEPTH); computed from registered count only, never from out_ready (no pop-through when full).
- out_valid = (count != 0); out_result/out_flags = array[rp] (combinational read of registered storage).
- Push: array[wp] <= {in_result, in_flags}; wp <= wp+1. Pop: rp <= rp+1.
- count: push only +1; pop only −1; both or neither unchanged.
- in_valid while full: entry dropped, no state change except overflow_err <= 1.
- Sticky flags: on push, flags_sticky <= flags_sticky | in_flags. clr_sticky without push → 0. clr_sticky with push same cycle → flags_sticky <= in_flags (clear first, then accumulate).
- Consumer may hold out_ready high with out_valid low; no effect.
- Entries leave in strict arrival order; contents of a held head never change while out_valid=1 and out_ready=0.

## Timing
- Reset (rst=0, async): wp=rp=0, count=0, in_ready=1, out_valid=0, out_result=0, out_flags=0 (array cleared), flags_sticky=0, overflow_err=0. Reset mid-stream discards all entries immediately.
- Latency: entry pushed at edge N appears on out_* with out_valid=1 after edge N (visible cycle N+1); no same-cycle bypass.
- Throughput: one push and one pop per cycle sustained when 0 < count < DEPTH.
- Full with simultaneous pop: pop occurs, in_ready stays 0 that cycle, any push dropped (overflow_err set); in_ready rises the following cycle.
- Empty with push and out_ready: only the push takes effect; pop impossible (out_valid=0).
- flags_sticky and overflow_err update at the same edge as the causing push.

## Configuration
- FPADDSUB_STICKY_FLAGS_EN: defined → flags_sticky accumulation and clr_sticky behave as above. Undefined → flags_sticky tied to 5'b0, clr_sticky ignored, no sticky register synthesized. FIFO, overflow_err and handshake identical in both builds.

## Test plan
- Reset then single push 32'h3F800000/flags 5'b00001, out_ready=0 → next cycle out_valid=1, out_result=32'h3F800000, count=1; holds while out_ready=0; out_ready=1 one cycle → count=0, out_valid=0.
- Push 4 entries 32'h1..32'h4 back-to-back (DEPTH=4) → in_ready=0 after 4th; fifth push 32'h5 dropped, overflow_err=1; drain yields 1,2,3,4 in order.
- Continuous push+pop for 20 cycles with count=2 → count stays 2, every value appears in order, pointers wrap with no loss.
- Pushes with flags 5'b00100 then 5'b10000 → flags_sticky=5'b10100; clr_sticky with push flags 5'b00001 same cycle → flags_sticky=5'b00001; macro undefined → flags_sticky=0 throughout.
- Fill to 3 entries, assert rst=0 mid-cycle → out_valid=0, count=0, in_ready=1, overflow_err=0 immediately, before next edge.
- Full FIFO with out_ready=1 and in_valid=1 same cycle → one pop, push dropped, overflow_err=1, count=3 next cycle, in_ready=1.
